// File: rtl/muldiv_seq_unit_if.sv
// Request/response bundle between the execute stage and the iterative
// multiply/divide unit.
//   master : core side  - drives flush, request (in_valid/funct3/op_a/op_b)
//            and out_ready; observes in_ready, out_valid, result, busy
//   slave  : unit side  - the mirror image
interface muldiv_seq_unit_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      funct3;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;

   modport master (
      output flush, in_valid, funct3, op_a, op_b, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  flush, in_valid, funct3, op_a, op_b, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/muldiv_seq_unit.sv
// Iterative RV32M/RV64M multiply/divide execute unit.
// Decodes funct3 (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) and computes the
// result with one radix-2 step per cycle on operand magnitudes, followed by
// a sign fix-up in the last step.  Division by zero and signed overflow are
// resolved at accept time without iterating.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - slave side of muldiv_seq_unit_if (flush, request handshake,
//          response handshake, busy)
module muldiv_seq_unit #(
   parameter  int XLEN  = 32,
   localparam int CNT_W = $clog2(XLEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   muldiv_seq_unit_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_n;

   logic [CNT_W-1:0] cnt_r;
   logic [XLEN-1:0]  hi_r;       // mul: upper product half / div: partial remainder
   logic [XLEN-1:0]  lo_r;       // mul: multiplier, then low product / div: dividend, then quotient
   logic [XLEN-1:0]  opnd_r;     // multiplicand or divisor magnitude
   logic [2:0]       funct3_r;
   logic             neg_q_r;    // negate product / quotient at the end
   logic             neg_rem_r;  // negate remainder at the end
   logic [XLEN-1:0]  result_r;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             busy_r;

   logic             accept_s;
   logic             a_neg_s;
   logic             b_neg_s;
   logic [XLEN-1:0]  mag_a_s;
   logic [XLEN-1:0]  mag_b_s;
   logic             div_zero_s;
   logic             div_ovf_s;
   logic             special_s;
   logic [XLEN-1:0]  special_res_s;

   logic [XLEN:0]    mul_sum_s;
   logic [XLEN:0]    div_shift_s;
   logic [XLEN:0]    div_diff_s;
   logic [XLEN-1:0]  hi_n_s;
   logic [XLEN-1:0]  lo_n_s;
   logic [2*XLEN-1:0] prod_fix_s;
   logic [XLEN-1:0]  quo_fix_s;
   logic [XLEN-1:0]  rem_fix_s;
   logic [XLEN-1:0]  final_res_s;

   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   // Request decode: operand signedness, magnitudes and the no-iteration cases
   always_comb begin
      accept_s      = (state_r == IDLE) && bus.in_valid && !bus.flush;
      a_neg_s       = 1'b0;
      b_neg_s       = 1'b0;
      div_zero_s    = 1'b0;
      div_ovf_s     = 1'b0;
      special_res_s = {XLEN{1'b0}};
      if (bus.funct3[2]) begin
         // DIV/REM (funct3[0]==0) are signed, DIVU/REMU unsigned
         a_neg_s    = bus.op_a[XLEN-1] & ~bus.funct3[0];
         b_neg_s    = bus.op_b[XLEN-1] & ~bus.funct3[0];
         div_zero_s = (bus.op_b == {XLEN{1'b0}});
         div_ovf_s  = ~bus.funct3[0] && (bus.op_a == MIN_NEG) && (bus.op_b == ALL_ONES);
      end else begin
         // a signed for MUL/MULH/MULHSU, b signed for MUL/MULH only
         a_neg_s = bus.op_a[XLEN-1] & (bus.funct3[1:0] != 2'b11);
         b_neg_s = bus.op_b[XLEN-1] & ~bus.funct3[1];
      end
      mag_a_s   = a_neg_s ? ({XLEN{1'b0}} - bus.op_a) : bus.op_a;
      mag_b_s   = b_neg_s ? ({XLEN{1'b0}} - bus.op_b) : bus.op_b;
      special_s = div_zero_s | div_ovf_s;
      if (div_zero_s) begin
         special_res_s = bus.funct3[1] ? bus.op_a : ALL_ONES;
      end else if (div_ovf_s) begin
         special_res_s = bus.funct3[1] ? {XLEN{1'b0}} : bus.op_a;
      end else begin
         special_res_s = {XLEN{1'b0}};
      end
   end

   // One radix-2 iteration plus the sign fix-up used on the final step
   always_comb begin
      mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
      div_shift_s = {hi_r, lo_r[XLEN-1]};
      div_diff_s  = div_shift_s - {1'b0, opnd_r};
      hi_n_s      = hi_r;
      lo_n_s      = lo_r;
      if (funct3_r[2]) begin
         // Restoring divide: keep the difference only when it did not borrow
         if (!div_diff_s[XLEN]) begin
            hi_n_s = div_diff_s[XLEN-1:0];
            lo_n_s = {lo_r[XLEN-2:0], 1'b1};
         end else begin
            hi_n_s = div_shift_s[XLEN-1:0];
            lo_n_s = {lo_r[XLEN-2:0], 1'b0};
         end
      end else begin
         // Shift-add: the carry out of the add becomes the new top bit
         hi_n_s = mul_sum_s[XLEN:1];
         lo_n_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
      end
      prod_fix_s = neg_q_r ? ({(2*XLEN){1'b0}} - {hi_n_s, lo_n_s}) : {hi_n_s, lo_n_s};
      quo_fix_s  = neg_q_r ? ({XLEN{1'b0}} - lo_n_s) : lo_n_s;
      rem_fix_s  = neg_rem_r ? ({XLEN{1'b0}} - hi_n_s) : hi_n_s;
      if (funct3_r[2]) begin
         final_res_s = funct3_r[1] ? rem_fix_s : quo_fix_s;
      end else if (funct3_r[1:0] == 2'b00) begin
         final_res_s = prod_fix_s[XLEN-1:0];
      end else begin
         final_res_s = prod_fix_s[2*XLEN-1:XLEN];
      end
   end

   // Next-state decode
   always_comb begin
      state_n = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_n = special_s ? DONE : CALC;
            end else begin
               state_n = IDLE;
            end
         end
         CALC: begin
            if (bus.flush) begin
               state_n = IDLE;
            end else if (cnt_r == CNT_W'(1)) begin
               state_n = DONE;
            end else begin
               state_n = CALC;
            end
         end
         DONE: begin
            if (bus.flush || bus.out_ready) begin
               state_n = IDLE;
            end else begin
               state_n = DONE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State register and handshake outputs registered from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_n;
         in_ready_r  <= (state_n == IDLE);
         out_valid_r <= (state_n == DONE);
         busy_r      <= (state_n != IDLE);
      end
   end

   // Datapath: operand capture on accept, one step per CALC cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r     <= {CNT_W{1'b0}};
         hi_r      <= {XLEN{1'b0}};
         lo_r      <= {XLEN{1'b0}};
         opnd_r    <= {XLEN{1'b0}};
         funct3_r  <= 3'b000;
         neg_q_r   <= 1'b0;
         neg_rem_r <= 1'b0;
         result_r  <= {XLEN{1'b0}};
      end else if (accept_s) begin
         cnt_r     <= CNT_W'(XLEN);
         hi_r      <= {XLEN{1'b0}};
         lo_r      <= mag_a_s;
         opnd_r    <= mag_b_s;
         funct3_r  <= bus.funct3;
         neg_q_r   <= a_neg_s ^ b_neg_s;
         neg_rem_r <= a_neg_s & bus.funct3[2];
         if (special_s) begin
            result_r <= special_res_s;
         end else begin
            result_r <= result_r;
         end
      end else if ((state_r == CALC) && !bus.flush) begin
         cnt_r <= cnt_r - CNT_W'(1);
         hi_r  <= hi_n_s;
         lo_r  <= lo_n_s;
         if (cnt_r == CNT_W'(1)) begin
            result_r <= final_res_s;
         end else begin
            result_r <= result_r;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.result    = result_r;

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed bench for muldiv_seq_unit: XLEN=32 and XLEN=64 instances,
// hand-computed expected results and latencies.
module tb_muldiv_seq_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   muldiv_seq_unit_if #(.XLEN(32)) bus32 ();
   muldiv_seq_unit_if #(.XLEN(64)) bus64 ();

   muldiv_seq_unit #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
   muldiv_seq_unit #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present a request at a negedge; it is accepted at the next posedge
   task automatic start32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      bus32.in_valid = 1'b1;
      bus32.funct3   = f;
      bus32.op_a     = a;
      bus32.op_b     = b;
      @(negedge clk);
      bus32.in_valid = 1'b0;
   endtask

   // Latency = posedges after the accept edge until out_valid is seen high
   task automatic wait32(output int lat);
      lat = 1;
      while (!bus32.out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic op32(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
      int lat;
      start32(f, a, b);
      wait32(lat);
      check_eq({tag, " lat"}, 64'(lat), 64'(exp_lat));
      check_eq(tag, 64'(bus32.result), 64'(exp));
      bus32.out_ready = 1'b1;
      @(negedge clk);
      bus32.out_ready = 1'b0;
      check_eq({tag, " idle"}, 64'(bus32.in_ready), 64'd1);
   endtask

   task automatic op64(input string tag, input logic [2:0] f, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
      int lat;
      @(negedge clk);
      bus64.in_valid = 1'b1;
      bus64.funct3   = f;
      bus64.op_a     = a;
      bus64.op_b     = b;
      @(negedge clk);
      bus64.in_valid = 1'b0;
      lat = 1;
      while (!bus64.out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      check_eq({tag, " lat"}, 64'(lat), 64'(exp_lat));
      check_eq(tag, bus64.result, exp);
      bus64.out_ready = 1'b1;
      @(negedge clk);
      bus64.out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      logic seen;
      bus32.flush = 1'b0; bus32.in_valid = 1'b0; bus32.funct3 = 3'd0;
      bus32.op_a = 32'd0; bus32.op_b = 32'd0; bus32.out_ready = 1'b0;
      bus64.flush = 1'b0; bus64.in_valid = 1'b0; bus64.funct3 = 3'd0;
      bus64.op_a = 64'd0; bus64.op_b = 64'd0; bus64.out_ready = 1'b0;

      #12;
      check_eq("rst in_ready", 64'(bus32.in_ready), 64'd1);
      check_eq("rst out_valid", 64'(bus32.out_valid), 64'd0);
      check_eq("rst busy", 64'(bus32.busy), 64'd0);
      check_eq("rst result", 64'(bus32.result), 64'd0);
      check_eq("rst64 in_ready", 64'(bus64.in_ready), 64'd1);
      rst = 1'b0;

      // Multiply
      op32("mul",    3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
      op32("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      op32("mulh",   3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33);
      op32("mulhsu", 3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      // Divide
      op32("div",    3'b100, 32'hFFFF_FFF9,  32'd2, 32'hFFFF_FFFD, 33);
      op32("rem",    3'b110, 32'hFFFF_FFF9,  32'd2, 32'hFFFF_FFFF, 33);
      op32("divu",   3'b101, 32'hFFFF_FFF9,  32'd2, 32'h7FFF_FFFC, 33);
      op32("remu",   3'b111, 32'd7,          32'd2, 32'd1,         33);
      // Special cases
      op32("div0",   3'b100, 32'd5,          32'd0, 32'hFFFF_FFFF, 1);
      op32("remu0",  3'b111, 32'd5,          32'd0, 32'd5,         1);
      op32("divovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1);
      op32("removf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1);

      // Backpressure: result held while out_ready stays low
      start32(3'b101, 32'd100, 32'd7);
      wait32(lat);
      check_eq("bp lat", 64'(lat), 64'd33);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("bp result", 64'(bus32.result), 64'd14);
         check_eq("bp out_valid", 64'(bus32.out_valid), 64'd1);
         check_eq("bp in_ready", 64'(bus32.in_ready), 64'd0);
         check_eq("bp busy", 64'(bus32.busy), 64'd1);
      end
      bus32.out_ready = 1'b1;
      @(negedge clk);
      bus32.out_ready = 1'b0;
      check_eq("bp rel in_ready", 64'(bus32.in_ready), 64'd1);
      check_eq("bp rel out_valid", 64'(bus32.out_valid), 64'd0);
      check_eq("bp rel busy", 64'(bus32.busy), 64'd0);
      bus32.in_valid = 1'b1;
      bus32.funct3   = 3'b000;
      bus32.op_a     = 32'd3;
      bus32.op_b     = 32'd5;
      @(negedge clk);
      bus32.in_valid = 1'b0;
      check_eq("bp new busy", 64'(bus32.busy), 64'd1);
      check_eq("bp new in_ready", 64'(bus32.in_ready), 64'd0);
      wait32(lat);
      check_eq("bp new lat", 64'(lat), 64'd33);
      check_eq("bp new result", 64'(bus32.result), 64'd15);
      bus32.out_ready = 1'b1;
      @(negedge clk);
      bus32.out_ready = 1'b0;

      // Flush in the middle of CALC
      start32(3'b100, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      bus32.flush = 1'b1;
      @(negedge clk);
      bus32.flush = 1'b0;
      check_eq("flush in_ready", 64'(bus32.in_ready), 64'd1);
      check_eq("flush busy", 64'(bus32.busy), 64'd0);
      seen = bus32.out_valid;
      repeat (40) begin
         @(negedge clk);
         seen = seen | bus32.out_valid;
      end
      check_eq("flush no out_valid", 64'(seen), 64'd0);

      // Flush together with a request in IDLE: not accepted
      @(negedge clk);
      bus32.in_valid = 1'b1;
      bus32.flush    = 1'b1;
      bus32.funct3   = 3'b000;
      bus32.op_a     = 32'd9;
      bus32.op_b     = 32'd9;
      @(negedge clk);
      bus32.in_valid = 1'b0;
      bus32.flush    = 1'b0;
      check_eq("flushreq in_ready", 64'(bus32.in_ready), 64'd1);
      check_eq("flushreq busy", 64'(bus32.busy), 64'd0);

      // Asynchronous reset between clock edges in the middle of CALC
      start32(3'b101, 32'hFFFF_FFF9, 32'd2);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("arst in_ready", 64'(bus32.in_ready), 64'd1);
      check_eq("arst out_valid", 64'(bus32.out_valid), 64'd0);
      check_eq("arst busy", 64'(bus32.busy), 64'd0);
      check_eq("arst result", 64'(bus32.result), 64'd0);
      rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         seen = seen | bus32.out_valid;
      end
      check_eq("arst no out_valid", 64'(seen), 64'd0);

      // 64-bit instance
      op64("mulhu64", 3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 65);
      op64("div64",   3'b100, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9,
           64'hFFFF_FFFF_FFFF_FFF2, 65);
      op64("div0_64", 3'b100, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
